// File: rtl/act_unit_sched.sv
// Round-robin scheduler sharing one fixed-latency activation unit among N_REQ requesters.
// Optional ACT_SCHED_FIXED_PRIO_EN: strict lowest-index priority, no rotating pointer.
module act_unit_sched #(
  parameter int              WL       = 16,
  parameter int              N_REQ    = 4,
  parameter int              ID_W     = 2,
  parameter int              ACT_LAT  = 3,
  parameter logic [7:0]      TANH_MSK = 8'b0000_0100
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  sched_en_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [N_REQ*WL-1:0]   req_data_i,
  output logic [N_REQ-1:0]      req_ready_o,
  output logic                  act_valid_o,
  output logic [WL-1:0]         act_in_o,
  output logic                  act_sel_o,
  input  logic [WL-1:0]         act_out_i,
  output logic                  rsp_valid_o,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [WL-1:0]         rsp_data_o,
  output logic                  idle_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         base;
  logic                    win_vld;
  logic [ID_W-1:0]         win_id;
  logic                    xfer;
  logic [ACT_LAT:1]        vld_pipe_q;
  logic [ID_W-1:0]         id_pipe_q [ACT_LAT:1];
  logic                    rsp_valid_q;
  logic [ID_W-1:0]         rsp_id_q;
  logic [WL-1:0]           rsp_data_q;
  logic                    pipe_empty;

`ifdef ACT_SCHED_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  assign base     = rr_ptr_q;
  assign rr_ptr_d = (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)  rr_ptr_q <= '0;
    else if (xfer) rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Scan from the far end back toward base so the closest valid requester wins last.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      idx = (int'(base) + i) % N_REQ;
      if (req_valid_i[idx]) begin
        win_vld = 1'b1;
        win_id  = idx[ID_W-1:0];
      end
    end
  end

  assign xfer = (state_q == RUN) && win_vld;

  always_comb begin
    req_ready_o = '0;
    act_in_o    = '0;
    act_sel_o   = 1'b0;
    if (xfer) begin
      req_ready_o[win_id] = 1'b1;
      act_in_o            = req_data_i[win_id*WL +: WL];
      act_sel_o           = TANH_MSK[win_id];
    end
  end

  assign act_valid_o = xfer;

  // Tag pipe mirrors the activation unit latency; its last stage lines up with act_out_i.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vld_pipe_q <= '0;
      for (int s = 1; s <= ACT_LAT; s++) id_pipe_q[s] <= '0;
    end else begin
      vld_pipe_q[1] <= xfer;
      id_pipe_q[1]  <= win_id;
      for (int s = 2; s <= ACT_LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        id_pipe_q[s]  <= id_pipe_q[s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= vld_pipe_q[ACT_LAT];
      if (vld_pipe_q[ACT_LAT]) begin
        rsp_id_q   <= id_pipe_q[ACT_LAT];
        rsp_data_q <= act_out_i;
      end
    end
  end

  // A response sitting in the output register retires at the same edge as DRAIN->IDLE.
  assign pipe_empty = ~|vld_pipe_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sched_en_i) state_d = RUN;
      RUN:     if (!sched_en_i) state_d = DRAIN;
      DRAIN:   if (sched_en_i) state_d = RUN;
               else if (pipe_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign idle_o      = (state_q == IDLE);

endmodule

// File: tb/tb_act_unit_sched.sv
// Randomized + directed bench for act_unit_sched against a transaction-level scheduler model.
module tb_act_unit_sched;
  localparam int         WL = 16, N_REQ = 4, ID_W = 2, ACT_LAT = 3;
  localparam logic [7:0] TMSK = 8'b0000_0100;

  logic                clk = 1'b0;
  logic                rst_n, sched_en;
  logic [N_REQ-1:0]    req_valid, req_ready;
  logic [N_REQ*WL-1:0] req_data;
  logic                act_valid, act_sel, rsp_valid, idle;
  logic [WL-1:0]       act_in, act_out, rsp_data;
  logic [ID_W-1:0]     rsp_id;

  always #5 clk = ~clk;

  act_unit_sched #(.WL(WL), .N_REQ(N_REQ), .ID_W(ID_W), .ACT_LAT(ACT_LAT), .TANH_MSK(TMSK)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sched_en_i(sched_en),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .act_valid_o(act_valid), .act_in_o(act_in), .act_sel_o(act_sel), .act_out_i(act_out),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .idle_o(idle)
  );

  // Stand-in activation function: sigmoid -> x>>1, tanh -> x^16'h5A5A.
  function automatic logic [WL-1:0] act_f(input logic [WL-1:0] x, input logic sel);
    return sel ? (x ^ 16'h5A5A) : {1'b0, x[WL-1:1]};
  endfunction

  logic [WL-1:0] au_pipe [ACT_LAT];
  always @(posedge clk) begin
    au_pipe[0] <= act_f(act_in, act_sel);
    for (int s = 1; s < ACT_LAT; s++) au_pipe[s] <= au_pipe[s-1];
  end
  assign act_out = au_pipe[ACT_LAT-1];

  typedef struct {int due; int id; logic [WL-1:0] data;} rsp_t;
  rsp_t          exp_q[$];
  int            mode;      // 0 idle, 1 granting, 2 draining
  int            ptr;
  bit            known;
  int            cyc;
  logic [WL-1:0] last_data;
  logic [WL-1:0] dat_r [N_REQ];
  logic [N_REQ-1:0] vld_r;
  int            n_chk, n_pass;
  int            won;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step(input logic rst, input logic en, input logic [N_REQ-1:0] vld, output int w);
    int               k;
    logic [N_REQ-1:0] exp_rdy;
    @(posedge clk); #1;
    rst_n = rst; sched_en = en; req_valid = vld;
    for (int i = 0; i < N_REQ; i++) req_data[i*WL +: WL] = dat_r[i];
    @(negedge clk);
    w = -1;
    if (known && mode == 1)
      for (int i = 0; i < N_REQ; i++) begin
        k = (ptr + i) % N_REQ;
        if (w < 0 && vld[k]) w = k;
      end
    if (known) begin
      exp_rdy = (w >= 0) ? N_REQ'(1 << w) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("act_valid", 32'(act_valid), 32'(w >= 0));
      chk("act_in",    32'(act_in),    (w >= 0) ? 32'(dat_r[w]) : 32'd0);
      chk("act_sel",   32'(act_sel),   (w >= 0) ? 32'(TMSK[w]) : 32'd0);
      chk("idle",      32'(idle),      32'(mode == 0));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id",    32'(rsp_id),    32'(exp_q[0].id));
        chk("rsp_data",  32'(rsp_data),  32'(exp_q[0].data));
        last_data = exp_q[0].data;
        void'(exp_q.pop_front());
      end else begin
        chk("rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rsp_hold",  32'(rsp_data),  32'(last_data));
      end
    end
    if (!rst) begin
      mode = 0; ptr = 0; exp_q.delete(); last_data = '0; known = 1'b1;
    end else if (known) begin
      if (w >= 0) begin
        exp_q.push_back('{cyc + ACT_LAT + 1, w, act_f(dat_r[w], TMSK[w])});
`ifndef ACT_SCHED_FIXED_PRIO_EN
        ptr = (w + 1) % N_REQ;
`endif
      end
      case (mode)
        0: if (en) mode = 1;
        1: if (!en) mode = 2;
        default: if (en) mode = 1; else if (exp_q.size() == 0) mode = 0;
      endcase
    end
    cyc++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; known = 1'b0; mode = 0; ptr = 0; last_data = '0;
    rst_n = 1'b0; sched_en = 1'b1; req_valid = '1; req_data = '0;
    for (int i = 0; i < N_REQ; i++) dat_r[i] = 16'(i * 16'h1111 + 16'h0203);

    // Reset held with everything requesting
    repeat (2) step(1'b0, 1'b1, 4'hF, won);
    repeat (2) step(1'b1, 1'b0, 4'h0, won);

    // Single request from requester 1
    dat_r[1] = 16'h0100;
    repeat (2) step(1'b1, 1'b1, 4'b0010, won);
    repeat (6) step(1'b1, 1'b1, 4'b0000, won);

    // Round-robin from a fresh pointer
    step(1'b0, 1'b1, 4'h0, won);
    step(1'b1, 1'b1, 4'hF, won);
    repeat (8) step(1'b1, 1'b1, 4'hF, won);

    // Three transfers then drain
    repeat (3) step(1'b1, 1'b1, 4'hF, won);
    repeat (8) step(1'b1, 1'b0, 4'hF, won);

    // Mid-flight reset drops in-flight tags
    step(1'b1, 1'b1, 4'hF, won);
    repeat (2) step(1'b1, 1'b1, 4'hF, won);
    step(1'b0, 1'b1, 4'hF, won);
    repeat (3) step(1'b1, 1'b1, 4'hF, won);

    // Two-requester contention: alternates, or requester 0 only under fixed priority
    repeat (8) step(1'b1, 1'b1, 4'b0011, won);
    repeat (6) step(1'b1, 1'b0, 4'b0000, won);

    // Randomized traffic; a requester holds its operand until granted
    vld_r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_REQ; i++)
        if (!vld_r[i]) begin
          vld_r[i] = ($urandom_range(0, 9) < 6);
          dat_r[i] = 16'($urandom);
        end
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8), vld_r, won);
      if (won >= 0) vld_r[won] = 1'b0;
    end
    repeat (10) step(1'b1, 1'b0, 4'h0, won);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
